token_decoder: RTL and testbench
================================

Name: token_decoder

Overview:
Inverse of the string matcher: maps a token index back to its characters. On start, walks the vocab memory, which holds consecutive zero-terminated strings, and counts terminators until it reaches the token_id-th string (0-based). It then streams that string's characters out over a valid/ready interface. Sits between the token-id producer and the text output path, sharing the same asynchronous-read vocab memory port style as the matcher.

Parameters:
ADDR_WIDTH, 4, width of vocab addresses and of token_id
DATA_WIDTH, 8, character width; value 0 is the string terminator

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cs  input  1  start request, level-sampled in IDLE/F/NF
token_id  input  ADDR_WIDTH  index of string to emit, sampled when start accepted
vocab_start_addr  input  ADDR_WIDTH  first vocab address
vocab_end_addr  input  ADDR_WIDTH  exclusive end of vocab region
addr_v  output  ADDR_WIDTH  vocab read address (registered)
val_vocab  input  DATA_WIDTH  vocab data at addr_v, same cycle (combinational read)
out_char  output  DATA_WIDTH  emitted character
out_valid  output  1  out_char valid
out_ready  input  1  consumer accepts out_char
busy  output  1  high in SKIP/FETCH/HOLD
done  output  1  high in F or NF
found  output  1  high in F only

Behaviour:
- Reset (async, any state): state=IDLE, addr_v=vocab_start_addr, cnt=0, tid=0, out_char=0, out_valid=0, done=0, found=0. All outputs are registered or decoded from state.
- Internal registers:
  - cnt (ADDR_WIDTH): terminator count.
  - tid: latched token_id.
- IDLE: addr_v<=vocab_start_addr. If cs: tid<=token_id, cnt<=0, go SKIP.
- SKIP, checks in priority order each cycle:
  1. cnt==tid -> FETCH; addr_v held.
  2. addr_v==vocab_end_addr -> NF.
  3. Otherwise addr_v<=addr_v+1; if val_vocab==0 then cnt<=cnt+1.
- FETCH, checks in priority order:
  1. addr_v==vocab_end_addr -> NF; unterminated string.
  2. val_vocab==0 -> F.
  3. Otherwise out_char<=val_vocab, out_valid<=1, go HOLD.
- HOLD:
  - out_char and out_valid are held stable while out_ready=0.
  - On out_valid&out_ready: out_valid<=0, addr_v<=addr_v+1, go FETCH.
  - Throughput is 1 char per 2 cycles minimum.
- F: done=1, found=1. NF: done=1, found=0.
  - Both hold until cs=1, which restarts exactly as from IDLE (tid re-latched, cnt=0, addr_v=vocab_start_addr, done/found cleared next cycle, go SKIP).
- cs is ignored while busy; token_id changes after acceptance have no effect.
- An empty string (terminator immediately) is a valid token: zero characters emitted, then F.
- Characters already emitted before NF (unterminated tail) are valid beats; the consumer discards them when found=0.
- Latency, token 0, out_ready=1:
  - cs sampled at edge 0 -> SKIP.
  - Edge 1 -> FETCH.
  - Edge 2 -> out_valid=1 in cycle 3.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. A region with vocab_start_addr==vocab_end_addr is empty: any token -> NF with no output.
- No combinational path from out_ready or val_vocab to any output.

Test Plan:
1. Memory load and token 3:
   - Load mem[0..11] = 'h','i',0,'a',0,0,'c','a','t',0,'z','q'; vocab_start_addr=0, vocab_end_addr=12; token_id=3, out_ready=1.
   - Required: beats 'c','a','t'; then done=1, found=1; addr_v=9 in F.
2. Token 0:
   - Same memory, token_id=0.
   - Required: out_valid first high 3 cycles after cs; beats 'h','i'; F.
3. Token 2 (empty string):
   - Same memory, token_id=2.
   - Required: zero beats; F with found=1.
4. Out of range and unterminated:
   - token_id=5 -> zero beats, NF (done=1, found=0).
   - token_id=4 -> beats 'z','q', then NF.
5. Backpressure:
   - token_id=1; hold out_ready=0 for 5 cycles after out_valid rises.
   - Required: out_char='a' stable and out_valid high throughout; single beat on release; then F.
6. Reset and restart:
   - Assert rst_n=0 mid-HOLD -> immediately out_valid=0, busy=0, done=0.
   - After release, cs with token_id=3 -> 'c','a','t', F.
   - While in F, cs with token_id=1 -> done drops, beat 'a', F.

Source files
------------

// File: rtl/token_decoder.sv
// token_decoder: maps a token index back to its characters.
// Walks a vocab region of consecutive zero-terminated strings and counts
// terminators until it reaches the requested string. It then streams that
// string's characters over a valid/ready handshake. The vocab memory is
// read combinationally at the registered address addr_v.
module token_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ADDR_WIDTH-1:0] token_id,
  input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
  input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
  output logic [ADDR_WIDTH-1:0] addr_v,
  input  logic [DATA_WIDTH-1:0] val_vocab,
  output logic [DATA_WIDTH-1:0] out_char,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  found
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SKIP  = 3'd1,
    S_FETCH = 3'd2,
    S_HOLD  = 3'd3,
    S_F     = 3'd4,
    S_NF    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   tid_q, tid_d;
  logic [DATA_WIDTH-1:0]   out_char_q, out_char_d;
  logic                    out_valid_q, out_valid_d;

  // State and datapath registers; the address resets to the region start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= vocab_start_addr;
      cnt_q       <= '0;
      tid_q       <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      tid_q       <= tid_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: skip to the requested string, then emit it char by char.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    tid_d       = tid_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE, S_F, S_NF: begin
        // IDLE keeps the address parked at the region start; F/NF keep the
        // final address visible until a new request arrives.
        if (state_q == S_IDLE) begin
          addr_d = vocab_start_addr;
        end
        if (cs) begin
          tid_d   = token_id;
          cnt_d   = '0;
          addr_d  = vocab_start_addr;
          state_d = S_SKIP;
        end
      end

      S_SKIP: begin
        // Reaching the requested count wins over running off the region end,
        // so the empty tail after a final terminator is reported via FETCH.
        if (cnt_q == tid_q) begin
          state_d = S_FETCH;
        end else if (addr_q == vocab_end_addr) begin
          state_d = S_NF;
        end else begin
          addr_d = addr_q + ONE;
          if (val_vocab == '0) begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      S_FETCH: begin
        if (addr_q == vocab_end_addr) begin
          // String ran to the region end without a terminator.
          state_d = S_NF;
        end else if (val_vocab == '0) begin
          state_d = S_F;
        end else begin
          out_char_d  = val_vocab;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        // out_valid is always high here; wait for the consumer.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + ONE;
          state_d     = S_FETCH;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Status and data outputs come straight from registers or decoded state.
  always_comb begin
    addr_v    = addr_q;
    out_char  = out_char_q;
    out_valid = out_valid_q;
    busy      = (state_q == S_SKIP) || (state_q == S_FETCH) || (state_q == S_HOLD);
    done      = (state_q == S_F) || (state_q == S_NF);
    found     = (state_q == S_F);
  end

endmodule

// File: tb/tb_token_decoder.sv
// Testbench for token_decoder: directed steps followed by randomized tokens,
// all checked against a string-list reference model of the vocab region.
module tb_token_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic [3:0] token_id = '0;
  logic [3:0] vs = '0;
  logic [3:0] ve = '0;
  logic [3:0] addr_v;
  logic [7:0] val_vocab;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       found;

  logic [7:0] mem [16];

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         exp_found;
  logic [3:0] exp_addr;

  always #5 clk = ~clk;

  assign val_vocab = mem[addr_v];

  token_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cs               (cs),
    .token_id         (token_id),
    .vocab_start_addr (vs),
    .vocab_end_addr   (ve),
    .addr_v           (addr_v),
    .val_vocab        (val_vocab),
    .out_char         (out_char),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done),
    .found            (found)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the region is a sequence of strings separated by zeros; the
  // requested string is the id-th one. A terminated string ends found with
  // the address on its terminator; otherwise the address ends at the region end.
  function automatic void model(input logic [3:0] id);
    logic [3:0] p;
    int         k;
    exp_q.delete();
    exp_found = 1'b0;
    exp_addr  = ve;
    p = vs;
    k = 0;
    for (int n = 0; n < 16; n++) begin
      if (p == ve) break;
      if (mem[p] == 8'h00) begin
        if (k == int'(id)) begin
          exp_found = 1'b1;
          exp_addr  = p;
          break;
        end
        k++;
      end else if (k == int'(id)) begin
        exp_q.push_back(mem[p]);
      end
      p = p + 4'd1;
    end
  endfunction

  task automatic run_token(input logic [3:0] id, input int ready_pct, input int hold_n,
                           input string tag, output int first_lat);
    int held;
    bit finished;
    model(id);
    got_q.delete();
    first_lat = -1;
    held      = 0;
    finished  = 1'b0;
    @(negedge clk);
    token_id  = id;
    cs        = 1'b1;
    out_ready = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cs       = 1'b0;
        token_id = 4'($urandom);
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " done_cleared"}, 32'(done), 32'd0);
      end
      if (done) begin
        finished = 1'b1;
        cs       = 1'b0;
        break;
      end
      if (out_valid && first_lat < 0) first_lat = cyc;
      if (first_lat >= 0 && held < hold_n) begin
        check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() > 0) check({tag, " hold_char"}, 32'(out_char), 32'(exp_q[0]));
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      if (out_valid && out_ready) got_q.push_back(out_char);
      if (cyc > 1) cs = ($urandom_range(7) == 0);
    end
    out_ready = 1'b0;
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " beat_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, " beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    check({tag, " found"}, 32'(found), 32'(exp_found));
    check({tag, " addr_end"}, 32'(addr_v), 32'(exp_addr));
    check({tag, " valid_low_done"}, 32'(out_valid), 32'd0);
    $display("token %0d (%s): %0d beats, found=%0b, addr=%0d", id, tag, got_q.size(), found, addr_v);
  endtask

  initial begin
    int  lat;
    bit  saw;
    logic [7:0] init_mem [12];
    init_mem = '{8'h68, 8'h69, 8'h00, 8'h61, 8'h00, 8'h00,
                 8'h63, 8'h61, 8'h74, 8'h00, 8'h7a, 8'h71};
    for (int i = 0; i < 16; i++) mem[i] = (i < 12) ? init_mem[i] : 8'h55;
    vs = 4'd0;
    ve = 4'd12;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset found", 32'(found), 32'd0);
    check("reset out_char", 32'(out_char), 32'd0);
    check("reset addr_v", 32'(addr_v), 32'(vs));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed tokens on the reference memory
    run_token(4'd3, 100, 0, "tok3", lat);
    run_token(4'd0, 100, 0, "tok0", lat);
    check("tok0 latency", 32'(lat), 32'd3);
    run_token(4'd2, 100, 0, "tok2_empty", lat);
    run_token(4'd5, 100, 0, "tok5_range", lat);
    run_token(4'd4, 100, 0, "tok4_unterm", lat);
    run_token(4'd1, 100, 5, "tok1_backpressure", lat);

    // Asynchronous reset in the middle of HOLD
    @(negedge clk);
    token_id  = 4'd3;
    cs        = 1'b1;
    out_ready = 1'b0;
    saw       = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cs = 1'b0;
      if (out_valid) begin
        saw = 1'b1;
        break;
      end
    end
    check("rst_mid valid_seen", 32'(saw), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_token(4'd3, 100, 0, "after_rst_tok3", lat);
    run_token(4'd1, 100, 0, "restart_from_F_tok1", lat);

    // Empty region: every token is not found
    vs = 4'd5;
    ve = 4'd5;
    run_token(4'd0, 100, 0, "empty_region", lat);

    // Randomized memories, regions (including wrapping ones), ids and backpressure
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) begin
        for (int i = 0; i < 16; i++)
          mem[i] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
        vs = 4'($urandom);
        ve = 4'($urandom);
      end
      run_token(4'($urandom_range(6)), int'($urandom_range(100, 30)), 0, "random", lat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
